// File: rtl/control_unit.sv
// Program counter and instruction decoder for the accumulator processor.
// Decode is combinational from the fetched word; only the PC is registered.
module control_unit #(
  parameter int NBITS_0 = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NBITS_D-1:0] i_Instruction,
  output logic [NBITS_0-1:0] o_Addr,
  output logic [1:0]         o_SelA,
  output logic               o_SelB,
  output logic               o_WrAcc,
  output logic               o_Op,
  output logic               o_WrRam,
  output logic               o_RdRam,
  output logic [NBITS_0-1:0] o_Operand
);

  typedef enum logic [OPCODE-1:0] {
    OP_HLT  = 'd0,
    OP_STO  = 'd1,
    OP_LD   = 'd2,
    OP_LDI  = 'd3,
    OP_ADD  = 'd4,
    OP_ADDI = 'd5,
    OP_SUB  = 'd6,
    OP_SUBI = 'd7
  } opcode_e;

  localparam logic [1:0] SEL_A_RAM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  opcode_e            opcode;
  logic [NBITS_0-1:0] pc_q, pc_d;

  assign opcode = opcode_e'(i_Instruction[NBITS_D-1 -: OPCODE]);

  // HLT freezes the PC on itself, so the same HLT word is refetched until reset.
  always_comb begin
    pc_d = (opcode == OP_HLT) ? pc_q : pc_q + NBITS_0'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) pc_q <= '0;
    else          pc_q <= pc_d;
  end

  assign o_Addr = pc_q;

  // NOTE: every output gets a default before the case, so unlisted opcodes
  // decode to all-zero strobes and no latches are inferred.
  always_comb begin
    o_SelA    = SEL_A_RAM;
    o_SelB    = 1'b0;
    o_WrAcc   = 1'b0;
    o_Op      = 1'b0;
    o_WrRam   = 1'b0;
    o_RdRam   = 1'b0;
    o_Operand = '0;
    if (i_reset) begin
      o_Operand = i_Instruction[NBITS_0-1:0];
      case (opcode)
        OP_STO: o_WrRam = 1'b1;
        OP_LD: begin
          o_SelA  = SEL_A_RAM;
          o_RdRam = 1'b1;
          o_WrAcc = 1'b1;
        end
        OP_LDI: begin
          o_SelA  = SEL_A_IMM;
          o_WrAcc = 1'b1;
        end
        OP_ADD: begin
          o_SelA  = SEL_A_ALU;
          o_RdRam = 1'b1;
          o_WrAcc = 1'b1;
        end
        OP_ADDI: begin
          o_SelA  = SEL_A_ALU;
          o_SelB  = 1'b1;
          o_WrAcc = 1'b1;
        end
        OP_SUB: begin
          o_SelA  = SEL_A_ALU;
          o_Op    = 1'b1;
          o_RdRam = 1'b1;
          o_WrAcc = 1'b1;
        end
        OP_SUBI: begin
          o_SelA  = SEL_A_ALU;
          o_SelB  = 1'b1;
          o_Op    = 1'b1;
          o_WrAcc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a program-memory array drives the DUT and a
// reference model tracks the expected PC and decode outputs from the opcode table.
module tb_control_unit;

  localparam int NA = 11;
  localparam int ND = 16;
  localparam int DEPTH = 1 << NA;

  logic          clk;
  logic          rst_n;
  logic [ND-1:0] instr;
  logic [NA-1:0] addr, operand;
  logic [1:0]    sel_a;
  logic          sel_b, wr_acc, op, wr_ram, rd_ram;

  logic [ND-1:0] prog [DEPTH];

  int n_cmp  = 0;
  int n_fail = 0;
  int pc_m   = 0;

  // Expected {SelA, SelB, Op, WrAcc, WrRam, RdRam} per opcode 0..7; other opcodes are all-zero.
  logic [6:0] exp_tab [8];

  control_unit dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_Instruction(instr),
    .o_Addr       (addr),
    .o_SelA       (sel_a),
    .o_SelB       (sel_b),
    .o_WrAcc      (wr_acc),
    .o_Op         (op),
    .o_WrRam      (wr_ram),
    .o_RdRam      (rd_ram),
    .o_Operand    (operand)
  );

  always_comb instr = prog[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [ND-1:0] mk(input int opc, input int opnd);
    mk = {opc[4:0], opnd[NA-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (pc_m=%0h t=%0t)", tag, obs, exp, pc_m, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [ND-1:0] w;
    int            opc;
    logic [6:0]    e;
    logic [NA-1:0] e_opnd;
    w   = prog[pc_m];
    opc = int'(w[ND-1 -: 5]);
    e   = (rst_n && opc < 8) ? exp_tab[opc] : 7'd0;
    e_opnd = rst_n ? w[NA-1:0] : '0;
    check({tag, ".addr"}, 32'(addr), 32'(pc_m));
    check({tag, ".strobes"}, {25'd0, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram}, {25'd0, e});
    check({tag, ".operand"}, 32'(operand), 32'(e_opnd));
  endtask

  // One clock: advance the model across the rising edge, sample on the falling edge.
  task automatic step(input string tag);
    int opc;
    opc = int'(prog[pc_m][ND-1 -: 5]);
    @(posedge clk);
    if (rst_n && opc != 0) pc_m = (pc_m + 1) % DEPTH;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    pc_m  = 0;
    #1;
    check_all("reset_async");
  endtask

  task automatic fill_nops();
    for (int i = 0; i < DEPTH; i++) prog[i] = mk(int'($urandom_range(8, 31)), int'($urandom));
  endtask

  initial begin
    exp_tab[0] = 7'b00_0_0_0_0_0;  // HLT
    exp_tab[1] = 7'b00_0_0_0_1_0;  // STO
    exp_tab[2] = 7'b00_0_0_1_0_1;  // LD
    exp_tab[3] = 7'b01_0_0_1_0_0;  // LDI
    exp_tab[4] = 7'b10_0_0_1_0_1;  // ADD
    exp_tab[5] = 7'b10_1_0_1_0_0;  // ADDI
    exp_tab[6] = 7'b10_0_1_1_0_1;  // SUB
    exp_tab[7] = 7'b10_1_1_1_0_0;  // SUBI

    // Reset held across two edges with a live LDI at address 0: everything must stay zero.
    fill_nops();
    prog[0] = mk(3, 5);
    rst_n = 1'b0;
    pc_m  = 0;
    repeat (2) step("reset_hold");
    rst_n = 1'b1;
    #1 check_all("reset_release");
    repeat (3) step("post_reset");
    check("post_reset.addr3", 32'(addr), 32'd3);

    // Decode sweep followed by HLT at address 7.
    assert_reset();
    fill_nops();
    prog[0] = mk(3, 5);
    prog[1] = mk(5, 3);
    prog[2] = mk(1, 'h010);
    prog[3] = mk(2, 'h010);
    prog[4] = mk(4, 'h010);
    prog[5] = mk(6, 'h010);
    prog[6] = mk(7, 1);
    prog[7] = mk(0, 'h123);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all("sweep0");
    check("sweep0.operand_const", 32'(operand), 32'd5);
    repeat (7) step("sweep");
    check("hlt.addr_const", 32'(addr), 32'd7);
    repeat (12) step("hlt_hold");
    check("hlt.held_addr", 32'(addr), 32'd7);
    check("hlt.strobes_zero", {26'd0, sel_a, sel_b, op, wr_acc, wr_ram}, 32'd0);
    @(negedge clk);
    assert_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step("restart");
    check("restart.addr", 32'(addr), 32'd2);

    // Unknown opcode 11111 at address 2.
    assert_reset();
    fill_nops();
    prog[0] = mk(3, 1);
    prog[1] = mk(5, 2);
    prog[2] = mk(31, 'h7ff);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step("unk_pre");
    check("unk.strobes_zero", {26'd0, sel_a, sel_b, op, wr_acc, wr_ram}, 32'd0);
    check("unk.rd_zero", 32'(rd_ram), 32'd0);
    step("unk_adv");
    check("unk.addr3", 32'(addr), 32'd3);

    // Wrap through the full address space of NOPs.
    assert_reset();
    fill_nops();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEPTH - 1) step("wrap_run");
    check("wrap.top", 32'(addr), 32'h7ff);
    step("wrap");
    check("wrap.zero", 32'(addr), 32'd0);
    repeat (2) step("wrap_after");

    // Async reset between edges while the PC is 4.
    assert_reset();
    fill_nops();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step("mid_run");
    check("mid.addr4", 32'(addr), 32'd4);
    #2;
    rst_n = 1'b0;
    pc_m  = 0;
    #1;
    check("mid.addr_async", 32'(addr), 32'd0);
    check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("mid_restart");

    // Randomized programs with occasional HLT words and random reset pulses.
    for (int r = 0; r < 6; r++) begin
      assert_reset();
      for (int i = 0; i < DEPTH; i++) begin
        int opc;
        opc = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 31));
        prog[i] = mk(opc, int'($urandom));
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 39) == 0) begin
          assert_reset();
          @(negedge clk);
          rst_n = 1'b1;
          #1 check_all("rand_release");
        end else begin
          step("rand");
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
